uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl.sv | 131 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: serialises a WIDTH-bit word as
// start bit, LSB-first data bits, optional parity bit and one stop bit,
// one serial bit per CLK cycle. TX_OUT and Busy are registered outputs.
module uart_tx_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             Data_Valid,
  input  logic             PAR_EN,
  input  logic             par_bit,
  output logic             TX_OUT,
  output logic             Busy
);

  // A one-bit word still needs a one-bit counter, hence the floor of 1.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             par_en_q, par_en_nxt;
  logic             par_q, par_nxt;
  logic             tx_q, tx_nxt;
  logic             busy_q, busy_nxt;

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

  // State, frame registers and registered outputs; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      data_q   <= '0;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      data_q   <= data_nxt;
      cnt_q    <= cnt_nxt;
      par_en_q <= par_en_nxt;
      par_q    <= par_nxt;
      tx_q     <= tx_nxt;
      busy_q   <= busy_nxt;
    end
  end

  // Next-state and next-output decode; the data register shifts right so
  // that the bit to send next is always at position 0.
  always_comb begin
    state_nxt  = state;
    data_nxt   = data_q;
    cnt_nxt    = cnt_q;
    par_en_nxt = par_en_q;
    par_nxt    = par_q;
    tx_nxt     = tx_q;
    busy_nxt   = busy_q;

    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (Data_Valid) begin
          data_nxt   = P_DATA;
          par_en_nxt = PAR_EN;
          state_nxt  = START;
          tx_nxt     = 1'b0;
          busy_nxt   = 1'b1;
        end
      end

      START: begin
        // The parity calculator delivers its result one cycle after
        // acceptance, so it is captured here rather than in IDLE.
        par_nxt   = par_bit;
        tx_nxt    = data_q[0];
        data_nxt  = data_q >> 1;
        cnt_nxt   = '0;
        state_nxt = DATA;
      end

      DATA: begin
        if (cnt_q == LAST_BIT) begin
          if (par_en_q) begin
            state_nxt = PARITY;
            tx_nxt    = par_q;
          end else begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end
        end else begin
          tx_nxt   = data_q[0];
          data_nxt = data_q >> 1;
          cnt_nxt  = cnt_q + CNT_W'(1);
        end
      end

      PARITY: begin
        state_nxt = STOP;
        tx_nxt    = 1'b1;
      end

      STOP: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end

      default: begin
        // Unused encodings recover to an idle line immediately.
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl: frames are predicted from the serial framing
// rules (start, LSB-first data, optional parity, stop) and compared bit by bit.
module tb_uart_tx_ctrl;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic [WIDTH-1:0] P_DATA;
  logic             Data_Valid;
  logic             PAR_EN;
  logic             par_bit;
  logic             TX_OUT;
  logic             Busy;

  int tests = 0;
  int fails = 0;

  uart_tx_ctrl #(.WIDTH(WIDTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .par_bit    (par_bit),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  // Expected line levels for one frame, one entry per serial cycle.
  function automatic void build_frame(input logic [WIDTH-1:0] d, input logic pen,
                                      input logic pb, output logic exp_q[$]);
    exp_q = {};
    exp_q.push_back(1'b0);
    for (int b = 0; b < WIDTH; b++) exp_q.push_back(d[b]);
    if (pen) exp_q.push_back(pb);
    exp_q.push_back(1'b1);
  endfunction

  // Call with the frame's inputs already applied (Data_Valid=1) at a negedge.
  // mode 0: Data_Valid dropped after acceptance, inputs scrambled after latch.
  // mode 1: as 0 plus a spurious Data_Valid with 8'hFF mid-frame.
  // mode 2: Data_Valid held high; next frame's inputs loaded mid-frame.
  task automatic check_frame(input string name, input logic [WIDTH-1:0] d,
                             input logic pen, input logic pb, input int mode,
                             input logic [WIDTH-1:0] nd, input logic npen,
                             input logic npb);
    logic exp_q[$];
    build_frame(d, pen, pb, exp_q);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge CLK);
      tests++;
      if (TX_OUT !== exp_q[i] || Busy !== 1'b1) begin
        fails++;
        $display("FAIL %s bit%0d: TX_OUT=%b Busy=%b, expected TX_OUT=%b Busy=1",
                 name, i, TX_OUT, Busy, exp_q[i]);
      end
      if (i == 0 && mode != 2) Data_Valid = 1'b0;
      if (i == 1) begin
        if (mode == 2) begin
          P_DATA = nd; PAR_EN = npen; par_bit = npb;
        end else begin
          P_DATA = WIDTH'($urandom); PAR_EN = 1'($urandom); par_bit = 1'($urandom);
        end
      end
      if (mode == 1 && i == 3) begin
        Data_Valid = 1'b1; P_DATA = '1;
      end
      if (mode == 1 && i == exp_q.size() - 2) Data_Valid = 1'b0;
    end
    @(negedge CLK);
    tests++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL %s idle: TX_OUT=%b Busy=%b, expected TX_OUT=1 Busy=0",
               name, TX_OUT, Busy);
    end
  endtask

  task automatic apply(input logic [WIDTH-1:0] d, input logic pen, input logic pb);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pen; par_bit = pb; Data_Valid = 1'b1;
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      tests++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        fails++;
        $display("FAIL %s cyc%0d: TX_OUT=%b Busy=%b, expected TX_OUT=1 Busy=0",
                 name, i, TX_OUT, Busy);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1; Data_Valid = 1'b1; P_DATA = 8'h00; PAR_EN = 1'b1; par_bit = 1'b1;
    check_idle("reset_hold", 3);
    RST = 1'b0; Data_Valid = 1'b0;
    check_idle("reset_release", 2);
  endtask

  task automatic test_parity_frame();
    apply(8'hA5, 1'b1, 1'b0);
    check_frame("a5_par", 8'hA5, 1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_no_parity();
    apply(8'h01, 1'b0, 1'b1);
    check_frame("01_nopar", 8'h01, 1'b0, 1'b1, 0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_mid_dv();
    apply(8'hA5, 1'b1, 1'b0);
    check_frame("a5_ignore", 8'hA5, 1'b1, 1'b0, 1, '0, 1'b0, 1'b0);
    check_idle("after_ignore", 3);
  endtask

  task automatic test_back_to_back();
    apply(8'h3C, 1'b1, 1'b0);
    check_frame("b2b_3c", 8'h3C, 1'b1, 1'b0, 2, 8'hC3, 1'b1, 1'b0);
    check_frame("b2b_c3", 8'hC3, 1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
    check_idle("after_b2b", 2);
  endtask

  task automatic test_reset_mid_frame();
    logic exp_q[$];
    build_frame(8'h6B, 1'b1, 1'b1, exp_q);
    apply(8'h6B, 1'b1, 1'b1);
    // Index 5 is data bit 4 (index 0 is the start bit).
    for (int i = 0; i <= 5; i++) begin
      @(negedge CLK);
      tests++;
      if (TX_OUT !== exp_q[i] || Busy !== 1'b1) begin
        fails++;
        $display("FAIL rst_mid bit%0d: TX_OUT=%b Busy=%b, expected TX_OUT=%b Busy=1",
                 i, TX_OUT, Busy, exp_q[i]);
      end
      if (i == 0) Data_Valid = 1'b0;
    end
    RST = 1'b1;
    check_idle("rst_mid_abort", 1);
    RST = 1'b0;
    check_idle("rst_mid_after", 12);
    apply(8'h96, 1'b1, 1'b0);
    check_frame("rst_mid_next", 8'h96, 1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      logic [WIDTH-1:0] d;
      logic pen, pb;
      int gap;
      d   = WIDTH'($urandom);
      pen = 1'($urandom);
      pb  = 1'($urandom);
      gap = $urandom_range(0, 2);
      apply(d, pen, pb);
      check_frame($sformatf("rand%0d", n), d, pen, pb, 0, '0, 1'b0, 1'b0);
      if (gap > 0) check_idle($sformatf("rand_gap%0d", n), gap);
    end
  endtask

  initial begin
    RST = 1'b1; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; par_bit = 1'b0;
    test_reset();
    test_parity_frame();
    test_no_parity();
    test_ignore_mid_dv();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
